// File: rtl/op_pkg.sv
// Shared types and sizing for the round-robin operation-unit arbiter.
package op_pkg;

    localparam int DEF_N   = 4;
    localparam int DEF_BW  = 16;
    localparam int DEF_TMO = 15;

    function automatic int tmo_width(input int tmo);
        return $clog2(tmo + 1);
    endfunction

    localparam int TMO_W = tmo_width(DEF_TMO);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT_BUSY,
        ST_WAIT_DONE,
        ST_RESP
    } state_t;

endpackage

// File: rtl/op_rr_pick.sv
// Combinational round-robin pick: first set request at or after PTR, wrapping.
module op_rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  REQ,
    input  logic [IW-1:0] PTR,
    output logic          GRANT_VALID,
    output logic [IW-1:0] GRANT_IDX
);

    // Scan from the farthest offset down so the nearest requester wins last.
    always_comb begin
        GRANT_VALID = 1'b0;
        GRANT_IDX   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (REQ[(int'(PTR) + k) % N]) begin
                GRANT_VALID = 1'b1;
                GRANT_IDX   = IW'((int'(PTR) + k) % N);
            end
        end
    end

endmodule

// File: rtl/op_arbiter_rr.sv
// Shares one start/ready successor unit among N requesters, round-robin.
// States: IDLE arbitrate | LAUNCH raise start | WAIT_BUSY await ready fall | WAIT_DONE await result | RESP acknowledge
module op_arbiter_rr
    import op_pkg::*;
#(
    parameter int N   = DEF_N,
    parameter int BW  = DEF_BW,
    parameter int TMO = DEF_TMO
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [N-1:0]  REQ,
    input  logic [N*BW-1:0] OPS,
    output logic [N-1:0]  ACK,
    output logic          ERR,
    output logic [BW-1:0] RES,
    output logic          U_ST,
    output logic [BW-1:0] U_IN,
    input  logic          U_RD,
    input  logic [BW-1:0] U_RES
);

    localparam int IW = $clog2(N);
    localparam int TW = tmo_width(TMO);

    state_t        state_q, state_d;
    logic [IW-1:0] sel_q, sel_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [BW-1:0] opnd_q, opnd_d;
    logic [BW-1:0] res_q, res_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          err_q, err_d;

    logic [IW-1:0] nxt_ptr;
    logic [IW-1:0] pick_ptr;
    logic          grant_valid;
    logic [IW-1:0] grant_idx;
    logic          grant;

    assign nxt_ptr = (sel_q == IW'(N - 1)) ? '0 : sel_q + IW'(1);

    // RESP arbitrates with the already-advanced pointer so back-to-back grants cost no idle cycle.
    assign pick_ptr = (state_q == ST_RESP) ? nxt_ptr : ptr_q;

    op_rr_pick #(.N(N), .IW(IW)) u_pick (
        .REQ         (REQ),
        .PTR         (pick_ptr),
        .GRANT_VALID (grant_valid),
        .GRANT_IDX   (grant_idx)
    );

    assign grant = grant_valid && U_RD && (state_q == ST_IDLE || state_q == ST_RESP);

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        opnd_d  = opnd_q;
        res_d   = res_q;
        tmo_d   = tmo_q;
        err_d   = err_q;
        unique case (state_q)
            ST_IDLE: ;
            ST_LAUNCH: begin
                tmo_d   = TW'(TMO - 1);
                state_d = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (!U_RD) begin
                    state_d = ST_WAIT_DONE;
                end else if (tmo_q == '0) begin
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    tmo_d = tmo_q - TW'(1);
                end
            end
            ST_WAIT_DONE: begin
                if (U_RD) begin
                    res_d   = U_RES;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                ptr_d   = nxt_ptr;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (grant) begin
            sel_d   = grant_idx;
            opnd_d  = OPS[int'(grant_idx) * BW +: BW];
            err_d   = 1'b0;
            state_d = ST_LAUNCH;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            ptr_q   <= '0;
            opnd_q  <= '0;
            res_q   <= '0;
            tmo_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            opnd_q  <= opnd_d;
            res_q   <= res_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
        end
    end

    assign U_ST = (state_q == ST_LAUNCH) || (state_q == ST_WAIT_BUSY);
    assign U_IN = opnd_q;
    assign RES  = res_q;
    assign ACK  = (state_q == ST_RESP) ? (N'(1) << sel_q) : '0;
    assign ERR  = (state_q == ST_RESP) && err_q;

endmodule

// File: tb/tb_op_arbiter_rr.sv
// Bench for op_arbiter_rr: directed scenarios plus randomized round-robin traffic against a transaction model.
module tb_op_arbiter_rr;

    localparam int N   = 4;
    localparam int BW  = 16;
    localparam int TMO = 15;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic [N-1:0]  REQ = '0;
    logic [N*BW-1:0] OPS = '0;
    logic [N-1:0]  ACK;
    logic          ERR;
    logic [BW-1:0] RES;
    logic          U_ST;
    logic [BW-1:0] U_IN;
    logic          U_RD;
    logic [BW-1:0] U_RES;

    int n_checks = 0;
    int n_fail   = 0;

    logic stuck = 1'b0;
    logic st_prev;
    int   busy;

    op_arbiter_rr #(.N(N), .BW(BW), .TMO(TMO)) dut (
        .CLK(CLK), .RST(RST), .REQ(REQ), .OPS(OPS), .ACK(ACK), .ERR(ERR), .RES(RES),
        .U_ST(U_ST), .U_IN(U_IN), .U_RD(U_RD), .U_RES(U_RES)
    );

    always #5 CLK = ~CLK;

    // Successor unit: ready drops on the edge seeing a fresh start, returns two edges later.
    always @(posedge CLK) begin
        if (RST) begin
            U_RD    <= 1'b1;
            U_RES   <= '0;
            st_prev <= 1'b0;
            busy    <= 0;
        end else begin
            st_prev <= U_ST;
            if (U_ST && !st_prev && !stuck) begin
                U_RD  <= 1'b0;
                U_RES <= U_IN + 16'd1;
                busy  <= 2;
            end else if (busy > 0) begin
                busy <= busy - 1;
                if (busy == 1) U_RD <= 1'b1;
            end
        end
    end

    function automatic int rr(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++)
            if (v[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    task automatic wait_ack(output int cyc);
        cyc = 0;
        do begin
            @(negedge CLK);
            cyc++;
        end while (ACK == '0 && cyc < 60);
    endtask

    task automatic do_reset();
        REQ = '0;
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (ACK !== '0)   begin n_fail++; $display("FAIL reset_ack got %b exp 0", ACK); end
        n_checks++; if (ERR !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b exp 0", ERR); end
        n_checks++; if (RES !== '0)   begin n_fail++; $display("FAIL reset_res got %h exp 0", RES); end
        n_checks++; if (U_ST !== 1'b0) begin n_fail++; $display("FAIL reset_ust got %b exp 0", U_ST); end
        n_checks++; if (U_IN !== '0)  begin n_fail++; $display("FAIL reset_uin got %h exp 0", U_IN); end
    endtask

    task automatic test_single();
        int cyc;
        OPS[1*BW +: BW] = 16'h00FF;
        REQ = 4'b0010;
        wait_ack(cyc);
        REQ = '0;
        n_checks++; if (cyc !== 5)          begin n_fail++; $display("FAIL single_lat got %0d exp 5", cyc); end
        n_checks++; if (ACK !== 4'b0010)    begin n_fail++; $display("FAIL single_ack got %b exp 0010", ACK); end
        n_checks++; if (RES !== 16'h0100)   begin n_fail++; $display("FAIL single_res got %h exp 0100", RES); end
        n_checks++; if (ERR !== 1'b0)       begin n_fail++; $display("FAIL single_err got %b exp 0", ERR); end
        @(negedge CLK);
        n_checks++; if (ACK !== '0 || RES !== 16'h0100) begin n_fail++; $display("FAIL single_pulse got ack %b res %h exp 0000 0100", ACK, RES); end
    endtask

    // Pointer sits at 2: 0011 grants 0 then 1, then 1010 grants 3 before 1.
    task automatic test_pointer();
        int cyc;
        int exp_idx [4] = '{0, 1, 3, 1};
        logic [N-1:0] nxt [4] = '{4'b0011, 4'b1010, 4'b0010, 4'b0000};
        for (int i = 0; i < N; i++) OPS[i*BW +: BW] = 16'(100 * (i + 1));
        REQ = 4'b0011;
        for (int t = 0; t < 4; t++) begin
            logic [N-1:0] ea;
            wait_ack(cyc);
            ea = '0; ea[exp_idx[t]] = 1'b1;
            REQ = nxt[t];
            n_checks++; if (ACK !== ea) begin n_fail++; $display("FAIL ptr_ack%0d got %b exp %b", t, ACK, ea); end
            n_checks++; if (RES !== 16'(100 * (exp_idx[t] + 1) + 1)) begin n_fail++; $display("FAIL ptr_res%0d got %0d exp %0d", t, RES, 100 * (exp_idx[t] + 1) + 1); end
            n_checks++; if (cyc !== 5) begin n_fail++; $display("FAIL ptr_lat%0d got %0d exp 5", t, cyc); end
        end
        @(negedge CLK);
    endtask

    task automatic test_wrap();
        int cyc;
        OPS[0 +: BW] = 16'hFFFF;
        REQ = 4'b0001;
        wait_ack(cyc);
        REQ = '0;
        n_checks++; if (ACK !== 4'b0001)  begin n_fail++; $display("FAIL wrap_ack got %b exp 0001", ACK); end
        n_checks++; if (RES !== 16'h0000) begin n_fail++; $display("FAIL wrap_res got %h exp 0000", RES); end
        n_checks++; if (ERR !== 1'b0 || cyc !== 5) begin n_fail++; $display("FAIL wrap_err_lat got %b/%0d exp 0/5", ERR, cyc); end
        @(negedge CLK);
    endtask

    task automatic test_fairness();
        int cyc;
        int order [5] = '{0, 1, 2, 3, 0};
        do_reset();
        for (int i = 0; i < N; i++) OPS[i*BW +: BW] = 16'(10 * (i + 1));
        REQ = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            logic [N-1:0] ea;
            wait_ack(cyc);
            if (t == 4) REQ = '0;
            ea = '0; ea[order[t]] = 1'b1;
            n_checks++; if (ACK !== ea) begin n_fail++; $display("FAIL fair_ack%0d got %b exp %b", t, ACK, ea); end
            n_checks++; if (RES !== 16'(10 * (order[t] + 1) + 1)) begin n_fail++; $display("FAIL fair_res%0d got %0d exp %0d", t, RES, 10 * (order[t] + 1) + 1); end
            n_checks++; if (cyc !== 5) begin n_fail++; $display("FAIL fair_gap%0d got %0d exp 5", t, cyc); end
        end
        @(negedge CLK);
    endtask

    // Pointer is 1 after fairness, so requester 2 gets the grant; RES keeps 11.
    task automatic test_timeout();
        int cyc;
        stuck = 1'b1;
        OPS[2*BW +: BW] = 16'h1234;
        REQ = 4'b0100;
        wait_ack(cyc);
        REQ = '0;
        n_checks++; if (cyc !== TMO + 2)  begin n_fail++; $display("FAIL tmo_lat got %0d exp %0d", cyc, TMO + 2); end
        n_checks++; if (ACK !== 4'b0100)  begin n_fail++; $display("FAIL tmo_ack got %b exp 0100", ACK); end
        n_checks++; if (ERR !== 1'b1)     begin n_fail++; $display("FAIL tmo_err got %b exp 1", ERR); end
        n_checks++; if (RES !== 16'd11)   begin n_fail++; $display("FAIL tmo_res got %0d exp 11", RES); end
        @(negedge CLK);
        n_checks++; if (ERR !== 1'b0 || ACK !== '0) begin n_fail++; $display("FAIL tmo_pulse got err %b ack %b exp 0 0000", ERR, ACK); end
        stuck = 1'b0;
    endtask

    // Pointer is 3 before reset; after reset 1010 must grant 1 (pointer back at 0).
    task automatic test_reset_midop();
        int cyc;
        OPS[0 +: BW] = 16'h0050;
        REQ = 4'b0001;
        repeat (3) @(negedge CLK);
        n_checks++; if (U_ST !== 1'b0 || U_RD !== 1'b0) begin n_fail++; $display("FAIL midop_state got ust %b rd %b exp 0 0", U_ST, U_RD); end
        RST = 1'b1;
        REQ = '0;
        @(negedge CLK);
        n_checks++; if (ACK !== '0 || ERR !== 1'b0) begin n_fail++; $display("FAIL midop_ack got %b/%b exp 0000/0", ACK, ERR); end
        n_checks++; if (RES !== '0 || U_IN !== '0 || U_ST !== 1'b0) begin n_fail++; $display("FAIL midop_outs got res %h uin %h ust %b exp 0 0 0", RES, U_IN, U_ST); end
        RST = 1'b0;
        OPS[1*BW +: BW] = 16'h0A00;
        OPS[3*BW +: BW] = 16'h0B00;
        REQ = 4'b1010;
        wait_ack(cyc);
        REQ = '0;
        n_checks++; if (ACK !== 4'b0010 || cyc !== 5) begin n_fail++; $display("FAIL midop_fresh got %b/%0d exp 0010/5", ACK, cyc); end
        n_checks++; if (RES !== 16'h0A01) begin n_fail++; $display("FAIL midop_res got %h exp 0a01", RES); end
        @(negedge CLK);
    endtask

    task automatic test_random();
        int cyc;
        int p;
        int e;
        logic [N-1:0] vec;
        logic [BW-1:0] ops_m [N];
        do_reset();
        p = 0;
        vec = N'($urandom_range(1, (1 << N) - 1));
        for (int i = 0; i < N; i++) begin
            ops_m[i] = BW'($urandom);
            OPS[i*BW +: BW] = ops_m[i];
        end
        REQ = vec;
        for (int t = 0; t < 40; t++) begin
            logic [N-1:0] ea;
            logic [N-1:0] add;
            wait_ack(cyc);
            e = rr(vec, p);
            ea = '0; ea[e] = 1'b1;
            n_checks++; if (ACK !== ea) begin n_fail++; $display("FAIL rnd_ack%0d got %b exp %b", t, ACK, ea); end
            n_checks++; if (RES !== BW'(ops_m[e] + 1)) begin n_fail++; $display("FAIL rnd_res%0d got %h exp %h", t, RES, BW'(ops_m[e] + 1)); end
            n_checks++; if (ERR !== 1'b0) begin n_fail++; $display("FAIL rnd_err%0d got %b exp 0", t, ERR); end
            n_checks++; if (cyc !== 5) begin n_fail++; $display("FAIL rnd_lat%0d got %0d exp 5", t, cyc); end
            p = (e + 1) % N;
            vec[e] = 1'b0;
            add = N'($urandom) & ~vec;
            if ((vec | add) == '0) add[$urandom_range(0, N - 1)] = 1'b1;
            for (int i = 0; i < N; i++) begin
                if (add[i]) begin
                    ops_m[i] = BW'($urandom);
                    OPS[i*BW +: BW] = ops_m[i];
                end
            end
            vec = vec | add;
            if (t == 39) vec = '0;
            REQ = vec;
        end
        @(negedge CLK);
    endtask

    initial begin
        @(negedge CLK);
        test_reset();
        test_single();
        test_pointer();
        test_wrap();
        test_fairness();
        test_timeout();
        test_reset_midop();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
